// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a req/ack instruction memory port
// and buffers fetched words in a two-entry queue ahead of the decode stage.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cu_wpcir,
    input  logic        cu_branch,
    input  logic [31:0] ID_new_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4,
    output logic [3:0]  IF_ins_type,
    output logic [3:0]  IF_ins_number
);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic [3:0]  typ;
        logic [3:0]  num;
    } entry_t;

    localparam logic [1:0] FULL = 2'(QDEPTH);

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] addr_next;
    logic [31:0] addr_plus4;
    logic [3:0]  seq, seq_next;
    logic [3:0]  last_num;
    entry_t      q0, q1, q0_next, q1_next;
    entry_t      new_entry;
    logic [1:0]  occ, occ_next;
    logic        push, pop;

    function automatic logic [3:0] decode_type(input logic [31:0] inst);
        logic [3:0] t;
        if (inst == 32'h0) begin
            t = 4'd0;
        end else begin
            case (inst[31:26])
                6'b000000:           t = 4'd1;
                6'b100011:           t = 4'd2;
                6'b101011:           t = 4'd3;
                6'b000100, 6'b000101: t = 4'd4;
                6'b000010, 6'b000011: t = 4'd5;
                default:             t = 4'd6;
            endcase
        end
        return t;
    endfunction

    assign addr_plus4 = imem_addr + 32'd4;
    assign push       = (state == REQ) && imem_ack && !cu_branch;
    assign pop        = !cu_wpcir && !cu_branch && (occ != 2'd0);
    assign new_entry  = {imem_rdata, addr_plus4, decode_type(imem_rdata), seq};

    // Queue update: flush wins, otherwise pop first so a same-cycle push lands behind the survivor.
    always_comb begin
        q0_next  = q0;
        q1_next  = q1;
        occ_next = occ;
        if (cu_branch) begin
            occ_next = 2'd0;
        end else begin
            if (pop) begin
                q0_next  = q1;
                occ_next = occ - 2'd1;
            end
            if (push) begin
                if (occ_next == 2'd0) begin
                    q0_next = new_entry;
                end else begin
                    q1_next = new_entry;
                end
                occ_next = occ_next + 2'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        addr_next  = imem_addr;
        seq_next   = seq;
        case (state)
            IDLE: begin
                if (cu_branch) begin
                    pc_next = ID_new_pc;
                end
                if (occ_next < FULL) begin
                    state_next = REQ;
                    addr_next  = cu_branch ? ID_new_pc : pc;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (cu_branch) begin
                        pc_next   = ID_new_pc;
                        addr_next = ID_new_pc;
                    end else begin
                        seq_next = seq + 4'd1;
                        pc_next  = addr_plus4;
                        if (occ_next < FULL) begin
                            addr_next = addr_plus4;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end else if (cu_branch) begin
                    // The outstanding fetch must still complete; its data is thrown away in DROP.
                    state_next = DROP;
                    pc_next    = ID_new_pc;
                end
            end
            DROP: begin
                if (cu_branch) begin
                    pc_next = ID_new_pc;
                end
                if (imem_ack) begin
                    state_next = REQ;
                    addr_next  = cu_branch ? ID_new_pc : pc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_addr <= RESET_PC;
            seq       <= 4'd0;
            last_num  <= 4'd0;
            occ       <= 2'd0;
            q0        <= '0;
            q1        <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            imem_addr <= addr_next;
            seq       <= seq_next;
            occ       <= occ_next;
            q0        <= q0_next;
            q1        <= q1_next;
            if (push) begin
                last_num <= seq;
            end
        end
    end

    assign imem_req      = (state != IDLE);
    assign if_inst       = (occ != 2'd0) ? q0.inst : 32'h0;
    assign if_pc4        = (occ != 2'd0) ? q0.pc4  : 32'h0;
    assign IF_ins_type   = (occ != 2'd0) ? q0.typ  : 4'd0;
    assign IF_ins_number = (occ != 2'd0) ? q0.num  : last_num;

endmodule
